// File: rtl/vcu_pkg.sv
// Shared types for the vector control sequencer: opcode/ALU encodings, FSM states
// and the packed bundle of controls latched at instruction accept.
package vcu_pkg;

  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_MUL = 3'b100,
    ALU_AVG = 3'b101,
    ALU_THR = 3'b110,
    ALU_SHL = 3'b111
  } alu_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MUL = 4'b0001;
  localparam logic [3:0] CMD_AVG = 4'b0011;
  localparam logic [3:0] CMD_THR = 4'b0101;
  localparam logic [3:0] CMD_SHL = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_HALTED = 2'b10
  } state_e;

  // pc_src and flag_write are pre-gating values; the top qualifies them with the last beat
  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       pc_src;
    alu_e       alu_ctrl;
    logic [1:0] flag_write;
    logic       one_beat;
  } ctrl_t;

endpackage

// File: rtl/vcu_main_decoder.sv
// Combinational decode of one instruction into the latched-control bundle plus
// an illegal-DP-function flag.
module vcu_main_decoder
  import vcu_pkg::*;
#(
  parameter int RD_W = 4
) (
  input  logic [1:0]      op,
  input  logic [5:0]      funct,
  input  logic [RD_W-1:0] rd,
  output ctrl_t           ctrl,
  output logic            illegal
);

  logic [3:0] cmd;
  logic       addsub;
  assign cmd    = funct[4:1];
  assign addsub = (cmd == CMD_ADD) || (cmd == CMD_SUB);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (op)
      OP_DP: begin
        ctrl.alu_src   = funct[5];
        ctrl.reg_write = 1'b1;
        unique case (cmd)
          CMD_ADD: ctrl.alu_ctrl = ALU_ADD;
          CMD_SUB: ctrl.alu_ctrl = ALU_SUB;
          CMD_AND: ctrl.alu_ctrl = ALU_AND;
          CMD_ORR: ctrl.alu_ctrl = ALU_ORR;
          CMD_MUL: ctrl.alu_ctrl = ALU_MUL;
          CMD_AVG: ctrl.alu_ctrl = ALU_AVG;
          CMD_THR: ctrl.alu_ctrl = ALU_THR;
          CMD_SHL: ctrl.alu_ctrl = ALU_SHL;
          default: illegal = 1'b1;
        endcase
        // undefined functions still run their beats but must not commit anything
        if (illegal) ctrl.reg_write = 1'b0;
        else         ctrl.flag_write = {funct[0], funct[0] & addsub};
      end
      OP_MEM: begin
        ctrl.imm_src    = 2'b01;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        if (funct[0]) begin
          ctrl.reg_write = 1'b1;
        end else begin
          ctrl.reg_src   = 2'b10;
          ctrl.mem_write = 1'b1;
        end
      end
      OP_BR: begin
        ctrl.reg_src  = 2'b01;
        ctrl.imm_src  = 2'b10;
        ctrl.alu_src  = 1'b1;
        ctrl.branch   = 1'b1;
        ctrl.one_beat = 1'b1;
      end
      default: ;
    endcase
    ctrl.pc_src = ((&rd) & ctrl.reg_write) | ctrl.branch;
  end

endmodule

// File: rtl/vector_control_sequencer.sv
// Decodes one instruction per handshake and replays its controls for VLEN/LANES
// beats; stalls decode while beats are outstanding, supports flush and sticky halt.
module vector_control_sequencer
  import vcu_pkg::*;
#(
  parameter int VLEN  = 16,
  parameter int LANES = 4,
  parameter int RD_W  = 4,
  localparam int BEATS = VLEN / LANES,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InstrValidD,
  input  logic [1:0]      Op,
  input  logic [5:0]      Funct,
  input  logic [RD_W-1:0] Rd,
  input  logic            FlushD,
  output logic            ReadyD,
  output logic            BeatValidD,
  output logic [CW-1:0]   BeatIdxD,
  output logic            LastBeatD,
  output logic            RegWriteD,
  output logic            MemWriteD,
  output logic            MemtoRegD,
  output logic            ALUSrcD,
  output logic            BranchD,
  output logic            PCSrcD,
  output logic [1:0]      ImmSrcD,
  output logic [1:0]      RegSrcD,
  output logic [2:0]      ALUControlD,
  output logic [1:0]      FlagWriteD,
  output logic            IllegalD,
  output logic            HaltedD
);

  state_e        state;
  logic [CW-1:0] cnt;
  ctrl_t         lat;
  logic          lat_ill;

  ctrl_t dec;
  logic  dec_ill;

  vcu_main_decoder #(.RD_W(RD_W)) u_dec (
    .op     (Op),
    .funct  (Funct),
    .rd     (Rd),
    .ctrl   (dec),
    .illegal(dec_ill)
  );

  logic issue, last, accept, is_halt;
  assign issue   = (state == S_ISSUE);
  assign last    = issue & (lat.one_beat | (cnt == CW'(BEATS - 1)));
  assign ReadyD  = ((state == S_IDLE) | last) & ~FlushD;
  assign accept  = InstrValidD & ReadyD;
  assign is_halt = (Op == OP_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      lat     <= '0;
      lat_ill <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_ISSUE: begin
          if (issue && FlushD) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (issue && !last) begin
            cnt <= cnt + 1'b1;
          end else if (accept) begin
            // idle accept and last-beat reload share this path, so streams never bubble
            cnt <= '0;
            if (is_halt) begin
              state <= S_HALTED;
            end else begin
              state   <= S_ISSUE;
              lat     <= dec;
              lat_ill <= dec_ill;
            end
          end else begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign BeatValidD  = issue;
  assign BeatIdxD    = issue ? cnt : '0;
  assign LastBeatD   = last;
  assign RegWriteD   = issue & lat.reg_write;
  assign MemWriteD   = issue & lat.mem_write;
  assign MemtoRegD   = issue & lat.mem_to_reg;
  assign ALUSrcD     = issue & lat.alu_src;
  assign BranchD     = issue & lat.branch;
  assign PCSrcD      = last & lat.pc_src;
  assign ImmSrcD     = issue ? lat.imm_src : 2'b00;
  assign RegSrcD     = issue ? lat.reg_src : 2'b00;
  assign ALUControlD = issue ? lat.alu_ctrl : ALU_ADD;
  assign FlagWriteD  = last ? lat.flag_write : 2'b00;
  assign IllegalD    = issue & lat_ill;
  assign HaltedD     = (state == S_HALTED);

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Directed self-checking bench for vector_control_sequencer (VLEN=16, LANES=4).
module tb_vector_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       InstrValidD = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'b0;
  logic       FlushD = 1'b0;
  logic       ReadyD, BeatValidD, LastBeatD;
  logic [1:0] BeatIdxD;
  logic       RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD, PCSrcD;
  logic [1:0] ImmSrcD, RegSrcD, FlagWriteD;
  logic [2:0] ALUControlD;
  logic       IllegalD, HaltedD;

  int checks = 0;
  int errors = 0;

  vector_control_sequencer #(.VLEN(16), .LANES(4), .RD_W(4)) dut (
    .clk(clk), .reset(reset), .InstrValidD(InstrValidD), .Op(Op), .Funct(Funct),
    .Rd(Rd), .FlushD(FlushD), .ReadyD(ReadyD), .BeatValidD(BeatValidD),
    .BeatIdxD(BeatIdxD), .LastBeatD(LastBeatD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .ImmSrcD(ImmSrcD), .RegSrcD(RegSrcD),
    .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .IllegalD(IllegalD),
    .HaltedD(HaltedD)
  );

  always #5 clk = ~clk;

  // observed outputs packed in the same order as ex()
  logic [21:0] ov;
  assign ov = {BeatValidD, BeatIdxD, LastBeatD, RegWriteD, MemWriteD, MemtoRegD,
               ALUSrcD, BranchD, PCSrcD, ImmSrcD, RegSrcD, ALUControlD, FlagWriteD,
               IllegalD, HaltedD, ReadyD};

  function automatic logic [21:0] ex(input logic v, input logic [1:0] idx,
      input logic last, input logic rw, input logic mw, input logic m2r,
      input logic as, input logic br, input logic pcs, input logic [1:0] imm,
      input logic [1:0] rs, input logic [2:0] alu, input logic [1:0] fw,
      input logic ill, input logic halt, input logic rdy);
    return {v, idx, last, rw, mw, m2r, as, br, pcs, imm, rs, alu, fw, ill, halt, rdy};
  endfunction

  localparam logic [21:0] IDLE_V = 22'h1;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd);
    InstrValidD = v; Op = op; Funct = f; Rd = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_instr(1'b0, 2'b00, 6'b0, 4'b0); FlushD = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL reset_state: got %h expected %h", ov, IDLE_V);
    end
  endtask

  task automatic test_adds();
    logic [21:0] e;
    set_instr(1'b1, 2'b00, 6'b101001, 4'd3);
    cyc();
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = ex(1, 2'(k), k == 3, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000,
             (k == 3) ? 2'b11 : 2'b00, 0, 0, k == 3);
      checks++;
      if (ov !== e) begin
        errors++; $display("FAIL adds beat %0d: got %h expected %h", k, ov, e);
      end
      cyc();
    end
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL adds_idle: got %h expected %h", ov, IDLE_V);
    end
  endtask

  // STR then LDR held valid throughout: LDR waits for the STR last beat, then follows it directly
  task automatic test_back_to_back();
    logic [21:0] e;
    set_instr(1'b1, 2'b01, 6'b000000, 4'd2);
    cyc();
    set_instr(1'b1, 2'b01, 6'b000001, 4'd4);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = ex(1, 2'(k), k == 3, 0, 1, 1, 1, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0, k == 3);
      checks++;
      if (ov !== e) begin
        errors++; $display("FAIL str beat %0d: got %h expected %h", k, ov, e);
      end
      cyc();
    end
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = ex(1, 2'(k), k == 3, 1, 0, 1, 1, 0, 0, 2'b01, 2'b00, 3'b000, 2'b00, 0, 0, k == 3);
      checks++;
      if (ov !== e) begin
        errors++; $display("FAIL ldr beat %0d: got %h expected %h", k, ov, e);
      end
      cyc();
    end
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL ldr_idle: got %h expected %h", ov, IDLE_V);
    end
  endtask

  task automatic test_branch_pc();
    logic [21:0] e;
    set_instr(1'b1, 2'b10, 6'b000000, 4'd0);
    cyc();
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    #1;
    e = ex(1, 2'd0, 1, 0, 0, 0, 1, 1, 1, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 1);
    checks++;
    if (ov !== e) begin
      errors++; $display("FAIL branch beat: got %h expected %h", ov, e);
    end
    cyc();
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL branch_idle: got %h expected %h", ov, IDLE_V);
    end
    // SUBS register form writing R15: PC update and flags only on the last beat
    set_instr(1'b1, 2'b00, 6'b000101, 4'd15);
    cyc();
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = ex(1, 2'(k), k == 3, 1, 0, 0, 0, 0, k == 3, 2'b00, 2'b00, 3'b001,
             (k == 3) ? 2'b11 : 2'b00, 0, 0, k == 3);
      checks++;
      if (ov !== e) begin
        errors++; $display("FAIL pc_write beat %0d: got %h expected %h", k, ov, e);
      end
      cyc();
    end
  endtask

  task automatic test_alu_map();
    logic [3:0]  cmds [8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100,
                              4'b0001, 4'b0011, 4'b0101, 4'b0111};
    logic [21:0] e;
    logic [1:0]  fw;
    set_instr(1'b1, 2'b00, {1'b0, cmds[0], 1'b1}, 4'd5);
    cyc();
    for (int i = 0; i < 8; i++) begin
      fw = (i < 2) ? 2'b11 : 2'b10;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) begin
          if (i < 7) set_instr(1'b1, 2'b00, {1'b0, cmds[i+1], 1'b1}, 4'd5);
          else       set_instr(1'b0, 2'b00, 6'b0, 4'd0);
        end
        #1;
        e = ex(1, 2'(k), k == 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'(i),
               (k == 3) ? fw : 2'b00, 0, 0, k == 3);
        checks++;
        if (ov !== e) begin
          errors++; $display("FAIL alu_map cmd %0d beat %0d: got %h expected %h", i, k, ov, e);
        end
        cyc();
      end
    end
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL alu_map_idle: got %h expected %h", ov, IDLE_V);
    end
  endtask

  task automatic test_illegal();
    logic [21:0] e;
    set_instr(1'b1, 2'b00, 6'b111111, 4'd15);
    cyc();
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = ex(1, 2'(k), k == 3, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, k == 3);
      checks++;
      if (ov !== e) begin
        errors++; $display("FAIL illegal beat %0d: got %h expected %h", k, ov, e);
      end
      cyc();
    end
  endtask

  task automatic test_flush();
    logic [21:0] e;
    set_instr(1'b1, 2'b00, 6'b001000, 4'd1);
    cyc();
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    cyc();
    FlushD = 1'b1;
    #1;
    e = ex(1, 2'd1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0);
    checks++;
    if (ov !== e) begin
      errors++; $display("FAIL flush_beat1: got %h expected %h", ov, e);
    end
    cyc();
    FlushD = 1'b0;
    #1;
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL flush_after: got %h expected %h", ov, IDLE_V);
    end
    // flush in IDLE masks ReadyD, so the simultaneous instruction is dropped
    FlushD = 1'b1;
    set_instr(1'b1, 2'b00, 6'b001000, 4'd1);
    #1;
    checks++;
    if (ov !== 22'h0) begin
      errors++; $display("FAIL flush_idle_ready: got %h expected %h", ov, 22'h0);
    end
    cyc();
    FlushD = 1'b0;
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    #1;
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL flush_idle_noaccept: got %h expected %h", ov, IDLE_V);
    end
  endtask

  task automatic test_reset_mid();
    set_instr(1'b1, 2'b01, 6'b000001, 4'd7);
    cyc();
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", ov, IDLE_V);
    end
    cyc();
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL reset_mid_nobeats: got %h expected %h", ov, IDLE_V);
    end
  endtask

  task automatic test_halt();
    localparam logic [21:0] HALT_V = 22'h2;
    set_instr(1'b1, 2'b11, 6'b0, 4'd0);
    cyc();
    #1;
    checks++;
    if (ov !== HALT_V) begin
      errors++; $display("FAIL halt_entry: got %h expected %h", ov, HALT_V);
    end
    for (int i = 0; i < 20; i++) begin
      set_instr(i[0], 2'b00, 6'b101001, 4'd3);
      FlushD = i[1];
      #1;
      checks++;
      if (ov !== HALT_V) begin
        errors++; $display("FAIL halt_sticky cycle %0d: got %h expected %h", i, ov, HALT_V);
      end
      cyc();
    end
    set_instr(1'b0, 2'b00, 6'b0, 4'd0);
    FlushD = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if (ov !== IDLE_V) begin
      errors++; $display("FAIL halt_reset: got %h expected %h", ov, IDLE_V);
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_back_to_back();
    test_branch_pc();
    test_alu_map();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
